// File: rtl/bcd_to_binary_converter_pkg.sv
// Shared constants and state encoding for the BCD-to-binary converter.
package bcd_to_binary_converter_pkg;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_MAX_DIGIT  = 9;
    localparam int BCD_ADJ_THRESH = 8;
    localparam int BCD_ADJ_SUB    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // 10^n, used for the elaboration-time width check
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/bcd_to_binary_converter_if.sv
// Start/busy/done handshake bundle between the digit entry logic and the converter.
interface bcd_to_binary_converter_if
    import bcd_to_binary_converter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 8
);
    logic                          start;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in;
    logic                          busy;
    logic                          done;
    logic [BIN_W-1:0]              result;
    logic                          error;

    modport master (output start, bcd_in, input busy, done, result, error);
    modport slave  (input start, bcd_in, output busy, done, result, error);
endinterface

// File: rtl/bcd_to_binary_converter_digit_adjust.sv
// Reverse double-dabble digit correction: subtract 3 from a nibble that is 8 or more.
module bcd_digit_adjust
    import bcd_to_binary_converter_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);
    logic w_adj;

    assign w_adj   = (i_digit >= BCD_DIGIT_W'(BCD_ADJ_THRESH));
    assign o_digit = w_adj ? (i_digit - BCD_DIGIT_W'(BCD_ADJ_SUB)) : i_digit;
endmodule

// File: rtl/bcd_to_binary_converter.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift per clock.
module bcd_to_binary_converter
    import bcd_to_binary_converter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 8
)(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    bcd_to_binary_converter_if.slave  io_bus
);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    generate
        if ((64'd1 << BIN_W) <= (pow10(DIGITS) - 64'd1)) begin : g_bad_width
            $fatal(1, "BIN_W too narrow for DIGITS BCD digits");
        end
    endgenerate

    state_t             r_state;
    logic [BCD_W-1:0]   r_bcd;
    logic [BIN_W-1:0]   r_bin;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err_flag;
    logic               r_busy;
    logic               r_done;
    logic [BIN_W-1:0]   r_result;
    logic               r_error;

    logic [BCD_W+BIN_W-1:0] w_shift;
    logic [BCD_W-1:0]       w_bcd_sh;
    logic [BCD_W-1:0]       w_bcd_adj;
    logic [BIN_W-1:0]       w_bin_sh;
    logic [DIGITS-1:0]      w_bad_vec;
    logic                   w_in_bad;

    // bcd LSB falls into the bin MSB
    assign w_shift  = {r_bcd, r_bin} >> 1;
    assign w_bcd_sh = w_shift[BCD_W+BIN_W-1 -: BCD_W];
    assign w_bin_sh = w_shift[BIN_W-1:0];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_adjust u_adj (
                .i_digit (w_bcd_sh[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
            assign w_bad_vec[g] =
                (io_bus.bcd_in[g*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT));
        end
    endgenerate

    assign w_in_bad = |w_bad_vec;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_bcd      <= '0;
            r_bin      <= '0;
            r_cnt      <= '0;
            r_err_flag <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_error    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.start) begin
                        r_bcd      <= io_bus.bcd_in;
                        r_bin      <= '0;
                        r_cnt      <= CNT_W'(BIN_W - 1);
                        r_error    <= 1'b0;
                        r_err_flag <= w_in_bad;
                        r_busy     <= 1'b1;
                        r_state    <= w_in_bad ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= w_bcd_adj;
                    r_bin <= w_bin_sh;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_result <= r_err_flag ? '0 : r_bin;
                    r_error  <= r_err_flag;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Legal input always drains the BCD register completely
    a_bcd_drained: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (r_state == ST_DONE && !r_err_flag) |-> (r_bcd == '0));

    assign io_bus.busy   = r_busy;
    assign io_bus.done   = r_done;
    assign io_bus.result = r_result;
    assign io_bus.error  = r_error;
endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Self-checking bench: vector table, random stimulus vs decimal reference model, corner sequences.
module tb_bcd_to_binary_converter;

    logic clk;
    logic rst_n;

    bcd_to_binary_converter_if #(.DIGITS(2), .BIN_W(8))  bi2();
    bcd_to_binary_converter_if #(.DIGITS(3), .BIN_W(10)) bi3();

    bcd_to_binary_converter #(.DIGITS(2), .BIN_W(8)) dut2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bi2)
    );

    bcd_to_binary_converter #(.DIGITS(3), .BIN_W(10)) dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bi3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] bcd;
        logic [7:0] res;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Decimal interpretation of packed BCD; any digit above 9 is an error with result 0
    function automatic void ref_model(input logic [31:0] bcd, input int digits,
                                      output int unsigned val, output bit err);
        int unsigned d;
        val = 0;
        err = 1'b0;
        for (int i = digits - 1; i >= 0; i--) begin
            d = (bcd >> (4 * i)) & 32'hF;
            if (d > 9) err = 1'b1;
            val = val * 10 + d;
        end
        if (err) val = 0;
    endfunction

    task automatic convert2(input logic [7:0] bcd, output logic [7:0] res, output logic err,
                            output int lat, output int nbusy);
        @(negedge clk);
        bi2.start  = 1'b1;
        bi2.bcd_in = bcd;
        @(posedge clk);
        @(negedge clk);
        bi2.start  = 1'b0;
        bi2.bcd_in = 8'($urandom);
        chk("err_cleared_on_accept", bi2.error, 0);
        lat   = 0;
        nbusy = bi2.busy ? 1 : 0;
        while (!bi2.done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bi2.busy) nbusy++;
        end
        if (!bi2.done) lat = -1;
        res = bi2.result;
        err = bi2.error;
        @(negedge clk);
        chk("done_one_cycle", bi2.done, 0);
    endtask

    task automatic convert3(input logic [11:0] bcd, output logic [9:0] res, output logic err,
                            output int lat);
        @(negedge clk);
        bi3.start  = 1'b1;
        bi3.bcd_in = bcd;
        @(posedge clk);
        @(negedge clk);
        bi3.start  = 1'b0;
        bi3.bcd_in = 12'($urandom);
        lat = 0;
        while (!bi3.done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bi3.done) lat = -1;
        res = bi3.result;
        err = bi3.error;
    endtask

    initial begin
        logic [7:0]  res8;
        logic [9:0]  res10;
        logic        err;
        int          lat;
        int          nbusy;
        int unsigned mval;
        bit          merr;
        logic [7:0]  rb8;
        logic [11:0] rb12;
        int          first_done;
        int          second_done;
        int          ndone;
        logic [7:0]  res_first;

        vecs[0] = '{8'h30, 8'd30, 1'b0, 9};
        vecs[1] = '{8'h99, 8'd99, 1'b0, 9};
        vecs[2] = '{8'h00, 8'd0,  1'b0, 9};
        vecs[3] = '{8'h09, 8'd9,  1'b0, 9};
        vecs[4] = '{8'h3A, 8'd0,  1'b1, 1};
        vecs[5] = '{8'h15, 8'd15, 1'b0, 9};
        vecs[6] = '{8'hF0, 8'd0,  1'b1, 1};

        rst_n      = 1'b0;
        bi2.start  = 1'b0;
        bi2.bcd_in = '0;
        bi3.start  = 1'b0;
        bi3.bcd_in = '0;
        #3;
        chk("reset_busy",   bi2.busy,   0);
        chk("reset_done",   bi2.done,   0);
        chk("reset_result", bi2.result, 0);
        chk("reset_error",  bi2.error,  0);
        #20;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            convert2(vecs[i].bcd, res8, err, lat, nbusy);
            chk($sformatf("vec%0d_result", i),  res8,  vecs[i].res);
            chk($sformatf("vec%0d_error", i),   err,   vecs[i].err);
            chk($sformatf("vec%0d_latency", i), lat,   vecs[i].lat);
            chk($sformatf("vec%0d_busy", i),    nbusy, vecs[i].lat);
        end

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) rb8 = 8'($urandom);
            else rb8 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            ref_model(32'(rb8), 2, mval, merr);
            convert2(rb8, res8, err, lat, nbusy);
            chk($sformatf("rnd_%02h_result", rb8),  res8, mval);
            chk($sformatf("rnd_%02h_error", rb8),   err,  merr);
            chk($sformatf("rnd_%02h_latency", rb8), lat,  merr ? 1 : 9);
        end

        // Start held high: back-to-back conversions every BIN_W+2 cycles
        @(negedge clk);
        bi2.start   = 1'b1;
        bi2.bcd_in  = 8'h25;
        first_done  = -1;
        second_done = -1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bi2.done) begin
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
        end
        bi2.start = 1'b0;
        chk("held_start_period", second_done - first_done, 10);
        chk("held_start_result", bi2.result, 25);
        repeat (12) @(negedge clk);

        // Start while busy is ignored
        @(negedge clk);
        bi2.start  = 1'b1;
        bi2.bcd_in = 8'h42;
        @(posedge clk);
        @(negedge clk);
        bi2.start = 1'b0;
        repeat (3) @(negedge clk);
        bi2.start  = 1'b1;
        bi2.bcd_in = 8'h11;
        @(negedge clk);
        bi2.start  = 1'b0;
        ndone      = 0;
        res_first  = '0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bi2.done) begin
                if (ndone == 0) res_first = bi2.result;
                ndone++;
            end
        end
        chk("busy_start_ndone",  ndone,       1);
        chk("busy_start_result", res_first,   42);
        chk("busy_start_held",   bi2.result,  42);

        // Asynchronous reset mid-conversion
        @(negedge clk);
        bi2.start  = 1'b1;
        bi2.bcd_in = 8'h77;
        @(posedge clk);
        @(negedge clk);
        bi2.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("pre_reset_busy", bi2.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy",   bi2.busy,   0);
        chk("async_rst_done",   bi2.done,   0);
        chk("async_rst_result", bi2.result, 0);
        chk("async_rst_error",  bi2.error,  0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        nbusy = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bi2.done) ndone++;
            if (bi2.busy) nbusy++;
        end
        chk("post_rst_no_done", ndone, 0);
        chk("post_rst_no_busy", nbusy, 0);

        // Three-digit configuration
        convert3(12'h999, res10, err, lat);
        chk("d3_999_result",  res10, 999);
        chk("d3_999_error",   err,   0);
        chk("d3_999_latency", lat,   11);
        convert3(12'h1F0, res10, err, lat);
        chk("d3_1F0_result",  res10, 0);
        chk("d3_1F0_error",   err,   1);
        chk("d3_1F0_latency", lat,   1);
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 3) == 0) rb12 = 12'($urandom);
            else rb12 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 9))};
            ref_model(32'(rb12), 3, mval, merr);
            convert3(rb12, res10, err, lat);
            chk($sformatf("d3_rnd_%03h_result", rb12),  res10, mval);
            chk($sformatf("d3_rnd_%03h_error", rb12),   err,   merr);
            chk($sformatf("d3_rnd_%03h_latency", rb12), lat,   merr ? 1 : 11);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
